// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display path.
package display_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    localparam bcd_digit_t BLANK_OVF_DIGIT = 4'hF;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction for one BCD nibble: add 3 when the nibble is 5 or more.
module bcd_digit_adjust
    import display_pkg::*;
(
    input  bcd_digit_t nib,
    output bcd_digit_t adj
);

    assign adj = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bin_to_bcd_display.sv
// Iterative binary-to-BCD converter with registered per-digit outputs,
// leading-zero blanking flags and an overflow indication.
module bin_to_bcd_display
    import display_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          value,
    input  logic                      lz_en,
    output logic                      busy,
    output logic                      done,
    output logic [DIGITS*DIGIT_W-1:0] digits,
    output logic [DIGITS-1:0]         leading_zero,
    output logic                      overflow
);

    localparam int BCD_W = DIGITS * DIGIT_W;
    localparam int CW    = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     LAST   = CW'(WIDTH - 1);
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    b2b_state_t        state_q, state_d;
    logic [WIDTH-1:0]  bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  bcd_adj;
    logic [CW-1:0]     cnt_q;
    logic              lz_q;
    logic              ovf_w;
    logic [DIGITS-1:0] lz_mask;
    logic              nz_acc;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .nib (bcd_q[g*DIGIT_W +: DIGIT_W]),
            .adj (bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Prefix-OR from the top digit down: a digit blanks only if it and
    // everything above it are zero. Digit 0 always shows.
    always_comb begin
        lz_mask = '0;
        nz_acc  = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc     = nz_acc | (|bcd_q[i*DIGIT_W +: DIGIT_W]);
            lz_mask[i] = lz_q & ~nz_acc;
        end
        lz_mask[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            lz_q         <= 1'b0;
            ovf_w        <= 1'b0;
            done         <= 1'b0;
            digits       <= '0;
            leading_zero <= LZ_RST;
            overflow     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bin_q <= value;
                        bcd_q <= '0;
                        cnt_q <= '0;
                        lz_q  <= lz_en;
                        ovf_w <= 1'b0;
                    end
                end
                SHIFT: begin
                    // The adjusted top bit is what falls off the BCD register.
                    bcd_q <= {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
                    bin_q <= bin_q << 1;
                    ovf_w <= ovf_w | bcd_adj[BCD_W-1];
                    cnt_q <= cnt_q + 1'b1;
                end
                DONE: begin
                    done <= 1'b1;
                    if (ovf_w) begin
                        digits       <= {DIGITS{BLANK_OVF_DIGIT}};
                        leading_zero <= '0;
                        overflow     <= 1'b1;
                    end else begin
                        digits       <= bcd_q;
                        leading_zero <= lz_mask;
                        overflow     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_display.sv
// Directed bench for bin_to_bcd_display: default build, a 3-digit build
// and a WIDTH=1 build, all checked against hand-computed values.
module tb_bin_to_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  start_v;
    logic [15:0] value;
    logic        lz_en;

    logic        busy6, done6, ovf6;
    logic [23:0] digits6;
    logic [5:0]  lz6;
    logic        busy3, done3, ovf3;
    logic [11:0] digits3;
    logic [2:0]  lz3;
    logic        busy1, done1, ovf1;
    logic [3:0]  digits1;
    logic [0:0]  lz1;

    int n_cmp = 0;
    int n_err = 0;
    int lat, bc, dcnt;

    always #5 clk = ~clk;

    bin_to_bcd_display #(.WIDTH(16), .DIGITS(6)) dut (
        .clk(clk), .rst(rst), .start(start_v[0]), .value(value), .lz_en(lz_en),
        .busy(busy6), .done(done6), .digits(digits6), .leading_zero(lz6), .overflow(ovf6)
    );

    bin_to_bcd_display #(.WIDTH(16), .DIGITS(3)) dut3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .value(value), .lz_en(lz_en),
        .busy(busy3), .done(done3), .digits(digits3), .leading_zero(lz3), .overflow(ovf3)
    );

    bin_to_bcd_display #(.WIDTH(1), .DIGITS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .value(value[0:0]), .lz_en(lz_en),
        .busy(busy1), .done(done1), .digits(digits1), .leading_zero(lz1), .overflow(ovf1)
    );

    function automatic logic get_done(input int sel);
        return (sel == 0) ? done6 : (sel == 1) ? done3 : done1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy6 : (sel == 1) ? busy3 : busy1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
            $error("comparison %s", tag);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic pulse(input int sel, input logic [15:0] v, input logic lz);
        value      = v;
        lz_en      = lz;
        start_v    = '0;
        start_v[sel] = 1'b1;
        @(negedge clk);
        start_v = '0;
    endtask

    // Counts negedges until done (bounded), and busy-high samples on the way.
    task automatic wait_done(input int sel, output int l, output int b);
        l = 0;
        b = get_busy(sel) ? 1 : 0;
        while (!get_done(sel) && l < 40) begin
            @(negedge clk);
            l++;
            if (get_busy(sel)) b++;
        end
    endtask

    initial begin
        rst = 1'b1; start_v = '0; value = '0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_digits", 64'(digits6), 64'h0);
        chk("rst_lz", 64'(lz6), 64'b111110);
        chk("rst_busy_done_ovf", {busy6, done6, ovf6}, 3'b000);
        chk("rst_lz_w1", 64'(lz1), 64'b0);
        rst = 1'b0;
        @(negedge clk);

        // zero with blanking
        pulse(0, 16'd0, 1'b1);
        chk("t1_busy_on_accept", 64'(busy6), 64'd1);
        wait_done(0, lat, bc);
        chk("t1_latency", 64'(lat), 64'd17);
        chk("t1_digits", 64'(digits6), 64'h000000);
        chk("t1_lz", 64'(lz6), 64'b111110);
        chk("t1_ovf", 64'(ovf6), 64'd0);
        @(negedge clk);
        chk("t1_done_single", 64'(done6), 64'd0);

        // maximum input
        pulse(0, 16'd65535, 1'b1);
        wait_done(0, lat, bc);
        chk("t2_busy_cycles", 64'(bc), 64'd17);
        chk("t2_digits", 64'(digits6), 64'h065535);
        chk("t2_lz", 64'(lz6), 64'b100000);

        // blanking disabled, then enabled
        @(negedge clk);
        pulse(0, 16'd1234, 1'b0);
        wait_done(0, lat, bc);
        chk("t3_digits", 64'(digits6), 64'h001234);
        chk("t3_lz_off", 64'(lz6), 64'b000000);
        @(negedge clk);
        pulse(0, 16'd1234, 1'b1);
        wait_done(0, lat, bc);
        chk("t3_lz_on", 64'(lz6), 64'b110000);

        // three-digit build: fits, overflows, recovers
        @(negedge clk);
        pulse(1, 16'd999, 1'b1);
        wait_done(1, lat, bc);
        chk("t4_999_digits", 64'(digits3), 64'h999);
        chk("t4_999_ovf", 64'(ovf3), 64'd0);
        chk("t4_999_lz", 64'(lz3), 64'b000);
        @(negedge clk);
        pulse(1, 16'd1000, 1'b1);
        wait_done(1, lat, bc);
        chk("t4_1000_digits", 64'(digits3), 64'hFFF);
        chk("t4_1000_ovf", 64'(ovf3), 64'd1);
        chk("t4_1000_lz", 64'(lz3), 64'b000);
        @(negedge clk);
        pulse(1, 16'd5, 1'b1);
        wait_done(1, lat, bc);
        chk("t4_5_digits", 64'(digits3), 64'h005);
        chk("t4_5_ovf_cleared", 64'(ovf3), 64'd0);
        chk("t4_5_lz", 64'(lz3), 64'b110);

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        pulse(0, 16'd42, 1'b1);
        repeat (3) @(negedge clk);
        pulse(0, 16'd5, 1'b1);
        wait_done(0, lat, bc);
        chk("t5_no_restart_lat", 64'(lat), 64'd13);
        chk("t5_digits_42", 64'(digits6), 64'h000042);
        pulse(0, 16'd7, 1'b1);
        chk("t5_done_cleared", 64'(done6), 64'd0);
        wait_done(0, lat, bc);
        chk("t5_b2b_latency", 64'(lat), 64'd17);
        chk("t5_digits_7", 64'(digits6), 64'h000007);

        // reset mid-conversion
        @(negedge clk);
        pulse(0, 16'd99, 1'b1);
        wait_done(0, lat, bc);
        chk("t6_prev_digits", 64'(digits6), 64'h000099);
        @(negedge clk);
        pulse(0, 16'd500, 1'b1);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t6_rst_digits", 64'(digits6), 64'h0);
        chk("t6_rst_lz", 64'(lz6), 64'b111110);
        chk("t6_rst_busy_done", {busy6, done6, ovf6}, 3'b000);
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done6) dcnt++;
        end
        chk("t6_no_done_after_rst", 64'(dcnt), 64'd0);
        pulse(0, 16'd500, 1'b1);
        wait_done(0, lat, bc);
        chk("t6_digits_500", 64'(digits6), 64'h000500);

        // reset and start together: reset wins
        @(negedge clk);
        rst = 1'b1; value = 16'd3; start_v = 3'b001;
        @(negedge clk);
        rst = 1'b0; start_v = '0;
        chk("t7_rst_beats_start", 64'(busy6), 64'd0);
        @(negedge clk);
        chk("t7_still_idle", 64'(busy6), 64'd0);

        // WIDTH=1 build
        pulse(2, 16'd1, 1'b1);
        wait_done(2, lat, bc);
        chk("t8_w1_latency", 64'(lat), 64'd2);
        chk("t8_w1_busy", 64'(bc), 64'd2);
        chk("t8_w1_digit", 64'(digits1), 64'h1);
        @(negedge clk);
        pulse(2, 16'd0, 1'b1);
        wait_done(2, lat, bc);
        chk("t8_w1_zero", 64'(digits1), 64'h0);
        chk("t8_w1_lz", 64'(lz1), 64'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_display.md
# bin_to_bcd_display

Sequential binary-to-BCD converter that feeds the per-digit seven-segment decoders on the DE10-Lite virtual board. It takes an unsigned binary value on a start pulse and runs an iterative double-dabble conversion. It then presents one 4-bit digit per display, with leading-zero blanking flags and an overflow flag. Digit outputs are registered and held stable between conversions, so the displays never show intermediate values.

## Interface
- WIDTH, 16: input value width in bits; must be ≥ 1.
- DIGITS, 6: number of BCD digits / displays driven; must be ≥ 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a conversion of `value`; sampled only in IDLE.
- value  in  WIDTH  unsigned binary input; captured on the accepted start edge.
- lz_en  in  1  leading-zero blanking enable; captured with `value`.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when new results appear on the outputs.
- digits  out  DIGITS×4  BCD digit i is `digits[4i+3:4i]`; digit 0 is least significant.
- leading_zero  out  DIGITS  per-digit blanking flag, wired to the decoder `leading_zero` input.
- overflow  out  1  the last captured value needed more than DIGITS decimal digits.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE:** when start=1, load `value` into the binary shift register, clear the BCD register (4·DIGITS bits) and the shift counter, capture `lz_en`, clear the working overflow, and go to SHIFT.
- **SHIFT:** each cycle runs one double-dabble step.
  - Every BCD nibble ≥ 5 gets +3.
  - Then {bcd, bin} shifts left by 1.
  - A 1 shifted out of the top BCD nibble sets the sticky working overflow.
  - After WIDTH steps, go to DONE.
- **DONE:** register the outputs, pulse done, return to IDLE.
  - If the working overflow is 0: `digits` = BCD register.
  - If the working overflow is 1: every digit = 4'hF (display reads "FFFF…") and `overflow` = 1.
- **Leading-zero flags:**
  - leading_zero[i] = lz_en & (every digit j ≥ i is 0).
  - leading_zero[0] is always 0, so a value of 0 displays as "0".
  - On overflow, all flags are 0.
- `start` outside IDLE (in SHIFT or DONE) is ignored. It is not queued.
- `value` changes after capture have no effect on a running conversion.

## Timing
- Let start be accepted at clock edge N.
  - busy = 1 from edge N to edge N+WIDTH+1.
  - SHIFT steps occur at edges N+1 … N+WIDTH.
  - At edge N+WIDTH+1, outputs update, done = 1 for exactly one cycle, and busy = 0.
  - Latency from start to done is WIDTH+1 cycles.
- The FSM is in IDLE during the done cycle, so a start in that cycle is accepted. The back-to-back period is WIDTH+1 cycles.
- Outputs change only at the DONE edge or on reset.
- **Reset (any state, including mid-conversion):**
  - The FSM goes to IDLE and any in-flight conversion is discarded; done is not pulsed.
  - digits = 0.
  - leading_zero = all ones except bit 0 (display shows "0").
  - busy = 0, done = 0, overflow = 0.
- Reset and start in the same cycle: reset wins and start is dropped.
- WIDTH = 1 is legal: one SHIFT step, latency 2.

## Structure
- **Shared package `display_pkg`:**
  - `DIGIT_W` = 4.
  - `bcd_digit_t` (logic [3:0]).
  - FSM enum `b2b_state_t` {IDLE, SHIFT, DONE}.
  - Constant `BLANK_OVF_DIGIT` = 4'hF.
- **Sub-module `bcd_digit_adjust`:** combinational; one 4-bit nibble in, the nibble +3 if ≥ 5 out. Instantiated DIGITS times in a generate loop.
- The shift counter width is $clog2(WIDTH+1).
- The leading-zero mask is a combinational prefix-OR from the top digit, registered in DONE.

## Test plan
1. Defaults (WIDTH=16, DIGITS=6): value=0, lz_en=1 -> after 17 cycles, digits = 0x000000, leading_zero = 6'b111110, overflow = 0, single done pulse.
2. value=65535, lz_en=1 -> digits = 0x065535, leading_zero = 6'b100000; busy high for exactly 17 cycles.
3. value=1234, lz_en=0 -> digits = 0x001234, leading_zero = 0; then value=1234 with lz_en=1 -> leading_zero = 6'b110000.
4. DIGITS=3: value=999 -> digits = 0x999, overflow = 0; value=1000 -> digits = 0xFFF, overflow = 1, leading_zero = 0.
5. Start 5 while busy converting 42 -> start ignored, result 0x000042, one done pulse. Start 7 in the done cycle -> accepted, result 0x000007 seventeen cycles later.
6. Reset 8 cycles into converting 500 (previous result 0x000099) -> digits = 0, leading_zero = 6'b111110, busy = 0, no done pulse. A next start of 500 yields 0x000500.
